flow_director_table: RTL and testbench

Next-generation flow director. Resolves the destination queue for every metadata beat whose `pkt_queue_id` is all-ones. It does this through a configurable exact-match flow table and falls back to destination-IP steering on a miss. The block is pipelined, backpressure-aware, and sits between the parser/metadata path and the PCIe queue manager. Metadata arriving with an already-assigned queue passes through with `pkt_flags` set to `PKT_PCIE`.

---
 rtl/flow_director_table.sv | 212 +++++++++++++++++++++
 tb/tb_flow_director_table.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_director_table.sv
// Flow director: exact-match flow table with dIP steering fallback.
// Build option FLOW_DIRECTOR_MISS_DROP_EN: misses are tagged PKT_DROP.
package flow_director_pkg;

  localparam int QID_W = 16;

  typedef struct packed {
    logic [31:0] sIP;
    logic [31:0] dIP;
    logic [15:0] sPort;
    logic [15:0] dPort;
  } tuple_t;

  typedef enum logic [1:0] {
    PKT_NONE = 2'd0,
    PKT_PCIE = 2'd1,
    PKT_DROP = 2'd2
  } pkt_flags_t;

  typedef struct packed {
    tuple_t           tuple;
    logic [15:0]      pkt_len;
    logic [QID_W-1:0] pkt_queue_id;
    pkt_flags_t       pkt_flags;
  } metadata_t;

endpackage

module flow_director_table
  import flow_director_pkg::*;
#(
  parameter int TABLE_DEPTH = 64,
  parameter int NB_QUEUES   = 1024,
  localparam int IDX_W      = $clog2(TABLE_DEPTH),
  localparam int Q_W        = $clog2(NB_QUEUES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  metadata_t        in_meta_data,
  input  logic             in_meta_valid,
  output logic             in_meta_ready,
  output metadata_t        out_meta_data,
  output logic             out_meta_valid,
  input  logic             out_meta_ready,
  input  logic             cfg_wr_valid,
  output logic             cfg_wr_ready,
  input  logic [IDX_W-1:0] cfg_wr_index,
  input  tuple_t           cfg_wr_key,
  input  logic [Q_W-1:0]   cfg_wr_queue,
  input  logic             cfg_wr_entry_valid,
  input  logic             cfg_clear,
  output logic             busy,
  output logic [31:0]      stat_hit,
  output logic [31:0]      stat_miss
);

  localparam int TW    = $bits(tuple_t);
  localparam int CH    = (TW + IDX_W - 1) / IDX_W;
  localparam int PAD_W = CH * IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TABLE_DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             run;

  logic [TABLE_DEPTH-1:0] ent_valid;
  tuple_t                 ent_key   [TABLE_DEPTH];
  logic [Q_W-1:0]         ent_queue [TABLE_DEPTH];

  logic             s1_valid;
  metadata_t        s1_data;
  logic [IDX_W-1:0] s1_idx;
  logic             s2_adv, s1_take;
  logic             in_fire, wr_fire;
  logic             lookup, hit;
  metadata_t        res;

  function automatic logic [IDX_W-1:0] fold(input tuple_t t);
    logic [PAD_W-1:0] pad;
    logic [IDX_W-1:0] h;
    pad = PAD_W'(t);
    h   = '0;
    for (int j = 0; j < CH; j++) h ^= pad[j*IDX_W +: IDX_W];
    return h;
  endfunction

  // State and sweep index register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Sweep sequencing, clear restart and mode outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run     = 1'b0;
    unique case (state_q)
      INIT: begin
        if (cfg_clear) begin
          idx_d = '0;
        end else if (idx_q == LAST) begin
          state_d = RUN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        run = 1'b1;
        if (cfg_clear) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy         = !run;
  assign cfg_wr_ready = run;
  assign wr_fire      = cfg_wr_valid && cfg_wr_ready;

  assign s2_adv        = !out_meta_valid || out_meta_ready;
  assign s1_take       = !s1_valid || s2_adv;
  assign in_meta_ready = run && s1_take;
  assign in_fire       = in_meta_valid && in_meta_ready;

  // Entry valid bits: swept clear in INIT, set/cleared by writes in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
    end else if (!run) begin
      ent_valid[idx_q] <= 1'b0;
    end else if (wr_fire) begin
      ent_valid[cfg_wr_index] <= cfg_wr_entry_valid;
    end
  end

  // Entry payload storage, meaningful only where the valid bit is set
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      ent_key[cfg_wr_index]   <= cfg_wr_key;
      ent_queue[cfg_wr_index] <= cfg_wr_queue;
    end
  end

  // S1: capture accepted beat and its hash index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_idx   <= '0;
    end else if (s1_take) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_data <= in_meta_data;
        s1_idx  <= fold(in_meta_data.tuple);
      end
    end
  end

  // Table compare and queue resolution for the beat leaving S1
  always_comb begin
    lookup        = &s1_data.pkt_queue_id;
    hit           = ent_valid[s1_idx] &&
                    (ent_key[s1_idx] == s1_data.tuple);
    res           = s1_data;
    res.pkt_flags = PKT_PCIE;
    if (lookup) begin
      if (hit) begin
        res.pkt_queue_id = QID_W'(ent_queue[s1_idx]);
      end else begin
`ifdef FLOW_DIRECTOR_MISS_DROP_EN
        res.pkt_flags = PKT_DROP;
`else
        res.pkt_queue_id = QID_W'(s1_data.tuple.dIP[Q_W-1:0]);
`endif
      end
    end
  end

  // S2: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_meta_valid <= 1'b0;
      out_meta_data  <= '0;
    end else if (s2_adv) begin
      out_meta_valid <= s1_valid;
      if (s1_valid) out_meta_data <= res;
    end
  end

  // Hit/miss counters, bumped on each lookup transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else if (s2_adv && s1_valid && lookup) begin
      if (hit) stat_hit  <= stat_hit + 32'd1;
      else     stat_miss <= stat_miss + 32'd1;
    end
  end

endmodule

// File: tb/tb_flow_director_table.sv
// Directed bench for flow_director_table.
// Exercises init sweep, hit/miss/pass-through, stall, hazard, clear, reset.
module tb_flow_director_table;
  import flow_director_pkg::*;

  localparam int IDX_W = 6;
  localparam int Q_W   = 10;

`ifdef FLOW_DIRECTOR_MISS_DROP_EN
  localparam logic [15:0] MISS_Q_U = 16'hFFFF;
  localparam logic [15:0] MISS_Q_T = 16'hFFFF;
  localparam logic [1:0]  MISS_F   = PKT_DROP;
`else
  localparam logic [15:0] MISS_Q_U = 16'h000D;
  localparam logic [15:0] MISS_Q_T = 16'h0002;
  localparam logic [1:0]  MISS_F   = PKT_PCIE;
`endif

  localparam logic [IDX_W-1:0] HASH_T = 6'd17;

  logic             clk = 1'b0;
  logic             rst_n;
  metadata_t        in_meta_data;
  logic             in_meta_valid;
  logic             in_meta_ready;
  metadata_t        out_meta_data;
  logic             out_meta_valid;
  logic             out_meta_ready;
  logic             cfg_wr_valid;
  logic             cfg_wr_ready;
  logic [IDX_W-1:0] cfg_wr_index;
  tuple_t           cfg_wr_key;
  logic [Q_W-1:0]   cfg_wr_queue;
  logic             cfg_wr_entry_valid;
  logic             cfg_clear;
  logic             busy;
  logic [31:0]      stat_hit;
  logic [31:0]      stat_miss;

  int        checks = 0;
  int        errors = 0;
  int        accepted = 0;
  metadata_t got_q[$];
  tuple_t    t_key, u_key;

  always #5 clk = ~clk;

  flow_director_table dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_meta_data       (in_meta_data),
    .in_meta_valid      (in_meta_valid),
    .in_meta_ready      (in_meta_ready),
    .out_meta_data      (out_meta_data),
    .out_meta_valid     (out_meta_valid),
    .out_meta_ready     (out_meta_ready),
    .cfg_wr_valid       (cfg_wr_valid),
    .cfg_wr_ready       (cfg_wr_ready),
    .cfg_wr_index       (cfg_wr_index),
    .cfg_wr_key         (cfg_wr_key),
    .cfg_wr_queue       (cfg_wr_queue),
    .cfg_wr_entry_valid (cfg_wr_entry_valid),
    .cfg_clear          (cfg_clear),
    .busy               (busy),
    .stat_hit           (stat_hit),
    .stat_miss          (stat_miss)
  );

  // Capture each beat consumed at the following rising edge
  always @(negedge clk)
    if (rst_n && out_meta_valid && out_meta_ready)
      got_q.push_back(out_meta_data);

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic metadata_t mk(input tuple_t t,
                                   input logic [15:0] qid);
    metadata_t m;
    m.tuple        = t;
    m.pkt_len      = 16'd64;
    m.pkt_queue_id = qid;
    m.pkt_flags    = PKT_NONE;
    return m;
  endfunction

  task automatic send(input metadata_t m);
    bit r = 1'b0;
    int n = 0;
    in_meta_data  = m;
    in_meta_valid = 1'b1;
    while (!r && n < 50) begin
      @(negedge clk);
      r = in_meta_ready;
      tick();
      n++;
    end
    in_meta_valid = 1'b0;
    if (r) accepted++;
    else chk("send_timeout", 64'(r), 64'd1);
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] idx,
                           input tuple_t k,
                           input logic [Q_W-1:0] q,
                           input logic v);
    bit r = 1'b0;
    int n = 0;
    cfg_wr_index       = idx;
    cfg_wr_key         = k;
    cfg_wr_queue       = q;
    cfg_wr_entry_valid = v;
    cfg_wr_valid       = 1'b1;
    while (!r && n < 50) begin
      @(negedge clk);
      r = cfg_wr_ready;
      tick();
      n++;
    end
    cfg_wr_valid = 1'b0;
    if (!r) chk("cfg_timeout", 64'(r), 64'd1);
  endtask

  task automatic wait_out(input string tag, input int n);
    int k = 0;
    while (got_q.size() < n && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 64'(got_q.size()), 64'(n));
  endtask

  task automatic chk_beat(input string tag, input metadata_t m,
                          input logic [15:0] q, input logic [1:0] f);
    chk({tag, "_q"}, 64'(m.pkt_queue_id), 64'(q));
    chk({tag, "_f"}, 64'(m.pkt_flags), 64'(f));
  endtask

  initial begin
    int rdy_seen;
    int n;
    rst_n              = 1'b0;
    in_meta_data       = '0;
    in_meta_valid      = 1'b0;
    out_meta_ready     = 1'b1;
    cfg_wr_valid       = 1'b0;
    cfg_wr_index       = '0;
    cfg_wr_key         = '0;
    cfg_wr_queue       = '0;
    cfg_wr_entry_valid = 1'b0;
    cfg_clear          = 1'b0;
    t_key = '{sIP: 32'h1, dIP: 32'h2, sPort: 16'h4, dPort: 16'h8};
    u_key = '{sIP: 32'h12345678, dIP: 32'h0A0B0C0D,
              sPort: 16'h1111, dPort: 16'h2222};

    repeat (3) tick();
    chk("rst_out_valid", 64'(out_meta_valid), 64'd0);
    chk("rst_in_ready", 64'(in_meta_ready), 64'd0);
    chk("rst_wr_ready", 64'(cfg_wr_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_hit", 64'(stat_hit), 64'd0);
    chk("rst_miss", 64'(stat_miss), 64'd0);
    chk("rst_out_data", 64'(out_meta_data), 64'd0);

    in_meta_data  = mk(u_key, 16'h0007);
    in_meta_valid = 1'b1;
    rst_n         = 1'b1;
    rdy_seen      = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (i < 64 && in_meta_ready) rdy_seen++;
      if (i == 63) chk("init_busy_63", 64'(busy), 64'd1);
    end
    chk("init_rdy_low", 64'(rdy_seen), 64'd0);
    chk("init_busy_64", 64'(busy), 64'd0);
    chk("init_rdy_64", 64'(in_meta_ready), 64'd1);
    chk("init_wr_rdy", 64'(cfg_wr_ready), 64'd1);

    tick();
    in_meta_valid = 1'b0;
    chk("lat_n1_valid", 64'(out_meta_valid), 64'd0);
    tick();
    chk("lat_n2_valid", 64'(out_meta_valid), 64'd1);
    chk_beat("first", out_meta_data, 16'h0007, PKT_PCIE);
    wait_out("first_cnt", 1);
    got_q.delete();

    cfg_write(HASH_T, t_key, 10'd5, 1'b1);
    send(mk(t_key, 16'hFFFF));
    wait_out("hit_cnt", 1);
    chk_beat("hit", got_q[0], 16'h0005, PKT_PCIE);
    chk("hit_stat", 64'(stat_hit), 64'd1);
    got_q.delete();

    send(mk(u_key, 16'hFFFF));
    wait_out("miss_cnt", 1);
    chk_beat("miss", got_q[0], MISS_Q_U, MISS_F);
    chk("miss_stat", 64'(stat_miss), 64'd1);
    got_q.delete();

    send(mk(t_key, 16'h0007));
    wait_out("pass_cnt", 1);
    chk_beat("pass", got_q[0], 16'h0007, PKT_PCIE);
    chk("pass_hit", 64'(stat_hit), 64'd1);
    chk("pass_miss", 64'(stat_miss), 64'd1);
    got_q.delete();

    accepted       = 0;
    out_meta_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(mk(u_key, 16'(100 + k)));
      end
    join_none
    repeat (10) tick();
    chk("bp_accepted", 64'(accepted), 64'd2);
    chk("bp_none_out", 64'(got_q.size()), 64'd0);
    chk("bp_in_ready", 64'(in_meta_ready), 64'd0);
    out_meta_ready = 1'b1;
    wait_out("bp_cnt", 5);
    repeat (3) tick();
    chk("bp_no_dup", 64'(got_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < got_q.size(); k++)
      chk($sformatf("bp_order%0d", k),
          64'(got_q[k].pkt_queue_id), 64'(100 + k));
    got_q.delete();

    cfg_write(HASH_T, t_key, 10'd0, 1'b0);
    in_meta_data  = mk(t_key, 16'hFFFF);
    in_meta_valid = 1'b1;
    @(negedge clk);
    chk("hz_in_ready", 64'(in_meta_ready), 64'd1);
    tick();
    in_meta_valid      = 1'b0;
    cfg_wr_index       = HASH_T;
    cfg_wr_key         = t_key;
    cfg_wr_queue       = 10'd6;
    cfg_wr_entry_valid = 1'b1;
    cfg_wr_valid       = 1'b1;
    @(negedge clk);
    chk("hz_wr_ready", 64'(cfg_wr_ready), 64'd1);
    tick();
    cfg_wr_valid = 1'b0;
    wait_out("hz_cnt", 1);
    chk_beat("hz_miss", got_q[0], MISS_Q_T, MISS_F);
    chk("hz_miss_stat", 64'(stat_miss), 64'd2);
    got_q.delete();
    send(mk(t_key, 16'hFFFF));
    wait_out("hz2_cnt", 1);
    chk_beat("hz_hit", got_q[0], 16'h0006, PKT_PCIE);
    chk("hz_hit_stat", 64'(stat_hit), 64'd2);
    got_q.delete();

    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    chk("clr_busy", 64'(busy), 64'd1);
    chk("clr_in_ready", 64'(in_meta_ready), 64'd0);
    chk("clr_wr_ready", 64'(cfg_wr_ready), 64'd0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("clr_busy_fall", 64'(busy), 64'd0);
    send(mk(t_key, 16'hFFFF));
    wait_out("clr_cnt", 1);
    chk_beat("clr_miss", got_q[0], MISS_Q_T, MISS_F);
    chk("clr_miss_stat", 64'(stat_miss), 64'd3);
    chk("clr_hit_stat", 64'(stat_hit), 64'd2);
    got_q.delete();

    out_meta_ready = 1'b0;
    send(mk(u_key, 16'h0007));
    send(mk(u_key, 16'hFFFF));
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_meta_valid), 64'd0);
    chk("mrst_hit", 64'(stat_hit), 64'd0);
    chk("mrst_miss", 64'(stat_miss), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd1);
    tick();
    rst_n          = 1'b1;
    out_meta_ready = 1'b1;
    repeat (70) tick();
    chk("mrst_dropped", 64'(got_q.size()), 64'd0);
    chk("mrst_idle", 64'(out_meta_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
